regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the CPU's 8x16 register file. It adds per-register pending (scoreboard) bits for multi-cycle loads, a separate load-fill write port, and a sequential post-reset clear sweep. Same-cycle write-to-read forwarding is selectable at compile time. It sits between the decoder, the writeback mux and the memory interface, and gives the CPU stall information for read-after-load hazards.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; NREGS = 2**ADDR_W entries
ZERO_REG, 0, 1 = register 0 reads as 0 and ignores all writes, reserves and fills

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
rd_busy_a  out  1  register at rd_addr_a is pending
rd_busy_b  out  1  register at rd_addr_b is pending
wr_en  in  1  ALU writeback enable
wr_addr  in  ADDR_W  ALU writeback address
wr_data  in  DATA_W  ALU writeback data
rsv_en  in  1  mark rsv_addr pending (load issued)
rsv_addr  in  ADDR_W  register to reserve
fill_en  in  1  load data return
fill_addr  in  ADDR_W  load destination
fill_data  in  DATA_W  load data
init_busy  out  1  clear sweep in progress; CPU must hold off
fill_err  out  1  sticky: fill arrived for a non-pending register

Behaviour:
- Reset: rst_n sampled low at a rising edge gives state INIT, sweep index = 0, all pending bits = 0, fill_err = 0, init_busy = 1. Register contents are not cleared by reset directly.
- INIT state:
  - Each cycle: reg[idx] <= 0, idx++.
  - After NREGS cycles (idx wraps from NREGS-1) go to RUN. init_busy = 0 from the first RUN cycle onward.
  - While in INIT: wr_en, rsv_en and fill_en are ignored (dropped, no error). Reads return stored contents, undefined until cleared. rd_busy = 0.
- Reset asserted mid-sweep restarts the sweep from idx 0.
- RUN state, per rising edge:
  - wr_en: reg[wr_addr] <= wr_data. Also clears pending[wr_addr] (a newer ALU write supersedes an outstanding load).
  - fill_en with pending[fill_addr] = 1: reg[fill_addr] <= fill_data, pending cleared.
  - fill_en with pending[fill_addr] = 0: fill is dropped and fill_err <= 1. fill_err stays set until reset.
  - rsv_en: pending[rsv_addr] <= 1.
- Same-cycle priority for the same address:
  - wr beats fill. Data = wr_data, pending cleared, the fill counts as consumed with no error.
  - rsv beats clear. Pending ends at 1 whatever wr or fill also did. Data still takes the wr or fill value.
- Different addresses update independently in the same cycle.
- rd_busy_x = pending[rd_addr_x] as registered. Same-cycle rsv, fill or wr does not affect rd_busy until the next cycle.
- ZERO_REG = 1, address 0:
  - rd_data = 0 and rd_busy = 0.
  - wr, fill and rsv are ignored; a fill to address 0 does not set fill_err.
- Latency:
  - Register write visible on rd_data the cycle after the edge.
  - With forwarding enabled (see Optional Feature), visible in the same cycle.
- Fills and writes are never queued; one of each per cycle maximum.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - rd_data_x returns wr_data when wr_en and wr_addr == rd_addr_x in RUN.
  - Otherwise returns fill_data when fill_en, fill_addr == rd_addr_x and pending is set.
  - Otherwise returns stored contents. wr has priority over fill, matching write priority.
- Undefined: rd_data_x always returns stored contents; new data appears one cycle later.
- Busy and pending logic is identical either way.

Test Plan:
1. Reset sweep: hold rst_n = 0 for 1 cycle, then release. init_busy = 1 for exactly 8 cycles. Afterwards all 8 registers read 0x0000. wr_en during the sweep (reg 3 = 0xBEEF) is dropped; reg 3 reads 0 after the sweep.
2. Write/read and forwarding: wr reg 5 = 0x1234 while reading addr 5 in the same cycle. With REGFILE_BYPASS_EN, rd_data_a = 0x1234 that cycle; without it, the old value that cycle and 0x1234 the next cycle.
3. Scoreboard: rsv reg 2, then rd_busy for addr 2 = 1 the next cycle. fill reg 2 = 0xA5A5 three cycles later gives busy = 0 and data = 0xA5A5 on the following cycle; fill_err stays 0.
4. Conflicts:
   - rsv reg 4, then same-cycle wr reg 4 = 0x0011 and fill reg 4 = 0x0022: reg 4 = 0x0011, busy = 0, fill_err = 0.
   - rsv and fill reg 6 in the same cycle while reg 6 is pending: data = fill_data and busy stays 1.
5. Error flag: fill reg 7 = 0xFFFF while not pending gives reg 7 unchanged and fill_err = 1, held until the next reset.
6. Reset mid-sweep and ZERO_REG: assert rst_n low at sweep cycle 4 and init_busy spans a full 8 cycles after release. With ZERO_REG = 1, wr reg 0 = 0x5555 still reads 0, and rsv reg 0 leaves busy = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised register file with a per-register load scoreboard.
//
// The block has two combinational read ports, an ALU writeback port and a
// load-fill port. A reserve port marks a register as pending when a load is
// issued, and the matching fill clears it. After reset, a sequential sweep
// clears every register, one per cycle. init_busy is high while that sweep
// runs.
//
// Compile-time option: define REGFILE_BYPASS_EN to forward same-cycle write
// or fill data onto the read ports. By default the macro is undefined, and
// stored contents are read.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, NREGS = 2**ADDR_W
//   ZERO_REG 1 = register 0 is hard-wired to zero
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   rd_addr_a/b             read addresses
//   rd_data_a/b             read data (combinational)
//   rd_busy_a/b             addressed register is pending (registered view)
//   wr_en/wr_addr/wr_data   ALU writeback
//   rsv_en/rsv_addr         reserve (mark pending) on load issue
//   fill_en/fill_addr/fill_data  load data return
//   init_busy               clear sweep in progress
//   fill_err                sticky: fill to a non-pending register
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              init_busy,
  output logic              fill_err
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              fill_err_q, fill_err_d;
  logic              run_s;

  // Register 0 is inert when it is hard-wired to zero.
  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  assign run_s = (state_q == ST_RUN);

  // State register: sweep FSM, scoreboard and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      idx_q      <= {ADDR_W{1'b0}};
      pending_q  <= {NREGS{1'b0}};
      fill_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      fill_err_q <= fill_err_d;
    end
  end

  // Register storage: reset does not touch contents; the sweep clears them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= regs_d;
    end else begin
      regs_q <= regs_q;
    end
  end

  // Next-state logic: leave INIT once the index wraps past the last register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (idx_q == ADDR_W'(NREGS - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Output logic of the FSM.
  always_comb begin
    init_busy = (state_q == ST_INIT);
  end

  // Datapath update. Fill is applied first. A write to the same register then
  // overrides it, and a reserve is applied last so that it wins over any clear.
  always_comb begin
    regs_d     = regs_q;
    pending_d  = pending_q;
    fill_err_d = fill_err_q;
    if (!run_s) begin
      regs_d[idx_q] = {DATA_W{1'b0}};
    end else begin
      if (fill_en && !is_zero(fill_addr)) begin
        if (pending_q[fill_addr]) begin
          regs_d[fill_addr]    = fill_data;
          pending_d[fill_addr] = 1'b0;
        end else if (!(wr_en && (wr_addr == fill_addr))) begin
          fill_err_d = 1'b1;
        end else begin
          // A same-cycle write to this register absorbs the fill silently.
          fill_err_d = fill_err_q;
        end
      end else begin
        fill_err_d = fill_err_q;
      end
      if (wr_en && !is_zero(wr_addr)) begin
        regs_d[wr_addr]    = wr_data;
        pending_d[wr_addr] = 1'b0;
      end else begin
        regs_d[wr_addr] = regs_d[wr_addr];
      end
      if (rsv_en && !is_zero(rsv_addr)) begin
        pending_d[rsv_addr] = 1'b1;
      end else begin
        pending_d[rsv_addr] = pending_d[rsv_addr];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = (p == 0) ? rd_addr_a : rd_addr_b;

    // Read mux: busy reflects the registered scoreboard only.
    always_comb begin
      data_s = regs_q[addr_s];
      busy_s = 1'b0;
      if (is_zero(addr_s)) begin
        data_s = {DATA_W{1'b0}};
      end else if (run_s) begin
        busy_s = pending_q[addr_s];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == addr_s)) begin
          data_s = wr_data;
        end else if (fill_en && (fill_addr == addr_s) && pending_q[addr_s]) begin
          data_s = fill_data;
        end else begin
          data_s = regs_q[addr_s];
        end
`else
        data_s = regs_q[addr_s];
`endif
      end else begin
        busy_s = 1'b0;
      end
    end
  end

  assign rd_data_a = g_rd[0].data_s;
  assign rd_data_b = g_rd[1].data_s;
  assign rd_busy_a = g_rd[0].busy_s;
  assign rd_busy_b = g_rd[1].busy_s;
  assign fill_err  = fill_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb, built with ZERO_REG = 1.
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;
  localparam int ZR = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr, fill_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data, fill_data;
  logic          rd_busy_a, rd_busy_b, wr_en, rsv_en, fill_en, init_busy, fill_err;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .init_busy(init_busy), .fill_err(fill_err)
  );

  typedef struct {
    bit            chk_a;
    bit            chk_b;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic          ba;
    logic          bb;
    logic          ib;
    logic          fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [N];
  bit            m_known [N];
  bit            m_pend [N];
  bit            m_err;
  int            m_init_left;
  bit            m_valid;

  function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                     output bit k, output logic b);
    d = m_mem[a];
    k = m_known[a];
    b = 1'b0;
    if (ZR != 0 && a == 3'd0) begin
      d = 16'h0000;
      k = 1'b1;
    end else if (m_init_left == 0) begin
      b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) begin
        d = wr_data; k = 1'b1;
      end else if (fill_en && fill_addr == a && m_pend[a]) begin
        d = fill_data; k = 1'b1;
      end
`endif
    end
  endfunction

  function automatic bit inert(input logic [AW-1:0] a);
    return (ZR != 0) && (a == 3'd0);
  endfunction

  task automatic step(input bit rst, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit re, input logic [AW-1:0] rsa,
                      input bit fe, input logic [AW-1:0] fa, input logic [DW-1:0] fd);
    exp_t e;
    bit   ka, kb;
    @(posedge clk);
    #2;
    rst_n = rst; rd_addr_a = ra; rd_addr_b = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = rsa;
    fill_en = fe; fill_addr = fa; fill_data = fd;
    if (m_valid) begin
      model_read(ra, e.da, ka, e.ba);
      model_read(rb, e.db, kb, e.bb);
      e.chk_a = ka;
      e.chk_b = kb;
      e.ib    = (m_init_left > 0);
      e.fe    = m_err;
      exp_q.push_back(e);
    end
    // Advance the model by the edge that ends this cycle.
    if (!rst) begin
      m_valid = 1'b1;
      m_init_left = N;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else if (m_valid) begin
      if (m_init_left > 0) begin
        m_mem[N - m_init_left] = 16'h0000;
        m_known[N - m_init_left] = 1'b1;
        m_init_left = m_init_left - 1;
      end else begin
        if (fe && !inert(fa)) begin
          if (m_pend[fa]) begin
            m_mem[fa] = fd; m_known[fa] = 1'b1; m_pend[fa] = 1'b0;
          end else if (!(we && wa == fa)) begin
            m_err = 1'b1;
          end
        end
        if (we && !inert(wa)) begin
          m_mem[wa] = wd; m_known[wa] = 1'b1; m_pend[wa] = 1'b0;
        end
        if (re && !inert(rsa)) m_pend[rsa] = 1'b1;
      end
    end
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b1, ra, rb, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("init_busy", {15'd0, init_busy}, {15'd0, e.ib});
      chk("fill_err",  {15'd0, fill_err},  {15'd0, e.fe});
      chk("rd_busy_a", {15'd0, rd_busy_a}, {15'd0, e.ba});
      chk("rd_busy_b", {15'd0, rd_busy_b}, {15'd0, e.bb});
      if (e.chk_a) chk("rd_data_a", rd_data_a, e.da);
      if (e.chk_b) chk("rd_data_b", rd_data_b, e.db);
    end
  end

  initial begin
    logic [AW-1:0] ra, rb, wa, rsa, fa;
    bit            we, re, fe, rs;
    m_valid = 1'b0; m_err = 1'b0; m_init_left = 0;
    for (int i = 0; i < N; i++) begin
      m_known[i] = 1'b0; m_pend[i] = 1'b0; m_mem[i] = 16'h0000;
    end
    rst_n = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    rsv_en = 1'b0; rsv_addr = 3'd0; fill_en = 1'b0; fill_addr = 3'd0; fill_data = 16'h0000;

    // Reset sweep with a dropped write and fill to reg 3 during it
    step(1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    step(1'b1, 3'd3, 3'd0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 1'b1, 3'd3, 16'h1111);
    for (int i = 0; i < 7; i++) rd(3'(i), 3'd3);
    rd(3'd0, 3'd1); rd(3'd2, 3'd3); rd(3'd4, 3'd5); rd(3'd6, 3'd7);

    // Write/read in the same cycle, then the cycle after
    step(1'b1, 3'd5, 3'd5, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    rd(3'd5, 3'd4);

    // Scoreboard reserve then fill three cycles later
    step(1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0000);
    rd(3'd2, 3'd1); rd(3'd2, 3'd1);
    step(1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd2, 16'hA5A5);
    rd(3'd2, 3'd2);

    // Write beats fill; reserve beats fill's clear
    step(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0000);
    step(1'b1, 3'd4, 3'd4, 1'b1, 3'd4, 16'h0011, 1'b0, 3'd0, 1'b1, 3'd4, 16'h0022);
    rd(3'd4, 3'd4);
    step(1'b1, 3'd6, 3'd6, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 1'b0, 3'd0, 16'h0000);
    step(1'b1, 3'd6, 3'd6, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 1'b1, 3'd6, 16'h0066);
    rd(3'd6, 3'd6);

    // Fill to a non-pending register sets the sticky error
    step(1'b1, 3'd7, 3'd7, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd7, 16'hFFFF);
    rd(3'd7, 3'd7); rd(3'd7, 3'd1); rd(3'd1, 3'd7);

    // Register 0 ignores write, reserve and fill
    step(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 16'h5555, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0000);
    step(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd0, 16'h7777);
    rd(3'd0, 3'd0);

    // Reset mid-sweep restarts the sweep
    step(1'b0, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 4; i++) rd(3'd1, 3'd2);
    step(1'b0, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 10; i++) rd(3'(i % 8), 3'd7);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rs  = ($urandom_range(0, 299) != 0);
      ra  = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
      we  = ($urandom_range(0, 2) == 0); wa = 3'($urandom_range(0, 7));
      re  = ($urandom_range(0, 2) == 0); rsa = 3'($urandom_range(0, 7));
      fa  = 3'($urandom_range(0, 7));
      fe  = m_pend[fa] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      if (fe && !m_pend[fa] && we && wa == fa) we = 1'b0;
      step(rs, ra, rb, we, wa, 16'($urandom), re, rsa, fe, fa, 16'($urandom));
    end
    rd(3'd0, 3'd1);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
